// File: rtl/audio_serializer.sv
// Serializes buffered multi-channel audio frames onto a codec bit clock in DSP, I2S or
// left-justified framing. Frame starts come from audio_sample_clk; frames are buffered in a small FIFO.
module audio_serializer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 16,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                 clk25,
  input  logic                                 reset25,
  input  logic                                 audio_bclk,
  input  logic                                 audio_sample_clk,
  input  logic [1:0]                           mode,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]     s_data,
  output logic                                 audio_dacdat,
  output logic                                 audio_daclrc,
  output logic                                 underrun,
  output logic                                 frame_abort,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

  localparam int unsigned FW = CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned N  = CHANNELS * SLOT_WIDTH;
  localparam int unsigned KW = $clog2(N + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_DSP = 2'd0,
    MODE_I2S = 2'd1,
    MODE_LJ  = 2'd2
  } mode_e;

  logic          bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic          sclk_q, sclk_prev_q;
  logic          pending_q, pending_d;
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  mode_e         mode_q, mode_d, mode_new;
  logic          active_q, active_d;
  logic [KW-1:0] k_q, k_d, k_last;
  logic [N-1:0]  sh_q, sh_d, stream, load;
  logic          dacdat_q, dacdat_d, daclrc_q, daclrc_d;
  logic          underrun_q, underrun_d, abort_q, abort_d;

  logic          bclk_fall, sclk_rise, start, full, empty, push, pop;
  logic [FW-1:0] head;

  assign bclk_fall = bclk_s3_q & ~bclk_s2_q;
  assign sclk_rise = sclk_q & ~sclk_prev_q;
  assign start     = bclk_fall & pending_q;
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign s_ready   = ~full & ~reset25;
  assign push      = s_valid & s_ready;
  assign pop       = start & ~empty;
  assign mode_new  = (mode == 2'd3) ? MODE_DSP : mode_e'(mode);
  assign k_last    = (mode_q == MODE_I2S) ? KW'(N) : KW'(N - 1);
  assign head      = mem_q[rd_ptr_q];

  // Stream bit j sits at stream[N-1-j]: slot-major, sample MSB first, zero padding at slot tail
  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    for (genvar p = 0; p < SLOT_WIDTH; p++) begin : g_bit
      if (p < SAMPLE_WIDTH) begin : g_data
        assign stream[N-1-(c*SLOT_WIDTH+p)] = head[c*SAMPLE_WIDTH+SAMPLE_WIDTH-1-p];
      end else begin : g_pad
        assign stream[N-1-(c*SLOT_WIDTH+p)] = 1'b0;
      end
    end
  end

  assign load = empty ? '0 : stream;

  // Next-state logic for FIFO bookkeeping and the serial framer
  always_comb begin
    pending_d  = start ? sclk_rise : (pending_q | sclk_rise);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    mode_d     = mode_q;
    active_d   = active_q;
    k_d        = k_q;
    sh_d       = sh_q;
    dacdat_d   = dacdat_q;
    daclrc_d   = daclrc_q;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    if (start) begin
      mode_d     = mode_new;
      active_d   = 1'b1;
      k_d        = '0;
      abort_d    = active_q;
      underrun_d = empty;
      if (mode_new == MODE_I2S) begin
        dacdat_d = 1'b0;
        daclrc_d = 1'b0;
        sh_d     = load;
      end else begin
        dacdat_d = load[N-1];
        daclrc_d = 1'b1;
        sh_d     = {load[N-2:0], 1'b0};
      end
    end else if (bclk_fall && active_q) begin
      if (k_q == k_last) begin
        active_d = 1'b0;
        dacdat_d = 1'b0;
        daclrc_d = (mode_q == MODE_I2S);
      end else begin
        k_d      = k_q + KW'(1);
        dacdat_d = sh_q[N-1];
        sh_d     = {sh_q[N-2:0], 1'b0};
        case (mode_q)
          MODE_LJ:  daclrc_d = (k_d < KW'(SLOT_WIDTH));
          MODE_I2S: daclrc_d = (k_d >= KW'(SLOT_WIDTH));
          default:  daclrc_d = 1'b0;
        endcase
      end
    end
  end

  // Sample-clock history reloads from the pin in reset so a level held high is not seen as an edge
  always_ff @(posedge clk25) begin
    if (reset25) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      sclk_q      <= audio_sample_clk;
      sclk_prev_q <= audio_sample_clk;
      pending_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mode_q      <= MODE_DSP;
      active_q    <= 1'b0;
      k_q         <= '0;
      sh_q        <= '0;
      dacdat_q    <= 1'b0;
      daclrc_q    <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      bclk_s1_q   <= audio_bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      sclk_q      <= audio_sample_clk;
      sclk_prev_q <= sclk_q;
      pending_q   <= pending_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mode_q      <= mode_d;
      active_q    <= active_d;
      k_q         <= k_d;
      sh_q        <= sh_d;
      dacdat_q    <= dacdat_d;
      daclrc_q    <= daclrc_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  always_ff @(posedge clk25) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign audio_dacdat = dacdat_q;
  assign audio_daclrc = daclrc_q;
  assign underrun     = underrun_q;
  assign frame_abort  = abort_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_audio_serializer.sv
// Directed bench for audio_serializer: three parameterizations share clock, bclk, sample clock and mode.
module tb_audio_serializer;

  logic        clk25 = 1'b0;
  logic        reset25 = 1'b1;
  logic        audio_bclk = 1'b1;
  logic        audio_sample_clk = 1'b0;
  logic [1:0]  mode = 2'd0;

  logic        s_valid0 = 1'b0, s_valid1 = 1'b0, s_valid2 = 1'b0;
  logic [31:0] s_data0 = '0, s_data1 = '0;
  logic [63:0] s_data2 = '0;
  logic        s_ready0, s_ready1, s_ready2;
  logic        dd0, dd1, dd2, lrc0, lrc1, lrc2;
  logic        und0, und1, und2, abt0, abt1, abt2;
  logic [2:0]  level0, level1, level2;

  int n_checks = 0;
  int n_fail   = 0;
  int und0_cnt = 0;
  int abt0_cnt = 0;

  audio_serializer u0 (
    .clk25(clk25), .reset25(reset25), .audio_bclk(audio_bclk), .audio_sample_clk(audio_sample_clk),
    .mode(mode), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .audio_dacdat(dd0), .audio_daclrc(lrc0), .underrun(und0), .frame_abort(abt0), .fifo_level(level0)
  );

  audio_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(24), .CHANNELS(2), .FIFO_DEPTH(4)) u1 (
    .clk25(clk25), .reset25(reset25), .audio_bclk(audio_bclk), .audio_sample_clk(audio_sample_clk),
    .mode(mode), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .audio_dacdat(dd1), .audio_daclrc(lrc1), .underrun(und1), .frame_abort(abt1), .fifo_level(level1)
  );

  audio_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(4), .FIFO_DEPTH(4)) u2 (
    .clk25(clk25), .reset25(reset25), .audio_bclk(audio_bclk), .audio_sample_clk(audio_sample_clk),
    .mode(mode), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .audio_dacdat(dd2), .audio_daclrc(lrc2), .underrun(und2), .frame_abort(abt2), .fifo_level(level2)
  );

  always #5 clk25 = ~clk25;
  always #40 audio_bclk = ~audio_bclk;

  // Pulse-width counters: a one-cycle pulse adds exactly one
  always @(posedge clk25) begin
    if (und0) und0_cnt++;
    if (abt0) abt0_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs for a bclk falling edge settle within 3 clk25 cycles; sample on the following rising bclk
  task automatic brise();
    @(posedge audio_bclk);
    #1;
  endtask

  task automatic push_u(input int sel, input logic [63:0] d);
    @(negedge clk25);
    case (sel)
      0: begin s_valid0 = 1'b1; s_data0 = d[31:0]; end
      1: begin s_valid1 = 1'b1; s_data1 = d[31:0]; end
      default: begin s_valid2 = 1'b1; s_data2 = d; end
    endcase
    @(negedge clk25);
    s_valid0 = 1'b0;
    s_valid1 = 1'b0;
    s_valid2 = 1'b0;
  endtask

  task automatic kick();
    brise();
    audio_sample_clk = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp1;
    logic [31:0] exp2;
    int u_base;
    int a_base;

    repeat (4) @(negedge clk25);
    check("rst dacdat", 64'(dd0), 64'd0);
    check("rst daclrc", 64'(lrc0), 64'd0);
    check("rst level", 64'(level0), 64'd0);
    check("rst s_ready", 64'(s_ready0), 64'd0);
    check("rst underrun", 64'(und0), 64'd0);
    check("rst abort", 64'(abt0), 64'd0);
    reset25 = 1'b0;
    @(negedge clk25);
    check("s_ready after rst", 64'(s_ready0), 64'd1);

    // DSP frame, mode change mid-frame must not alter framing
    mode = 2'd0;
    push_u(0, 64'hA5F0_8001);
    check("dsp level after push", 64'(level0), 64'd1);
    u_base = und0_cnt;
    exp1 = 32'h8001_A5F0;
    kick();
    for (int k = 0; k < 32; k++) begin
      brise();
      if (k == 0) audio_sample_clk = 1'b0;
      if (k == 3) mode = 2'd2;
      check($sformatf("dsp dacdat k=%0d", k), 64'(dd0), 64'(exp1[31-k]));
      check($sformatf("dsp daclrc k=%0d", k), 64'(lrc0), 64'(k == 0));
    end
    brise();
    check("dsp idle dacdat", 64'(dd0), 64'd0);
    check("dsp idle daclrc", 64'(lrc0), 64'd0);
    check("dsp level after pop", 64'(level0), 64'd0);
    check("dsp no underrun", 64'(und0_cnt - u_base), 64'd0);

    // Underrun: frame start with empty FIFO
    mode = 2'd0;
    u_base = und0_cnt;
    kick();
    for (int k = 0; k < 32; k++) begin
      brise();
      if (k == 0) audio_sample_clk = 1'b0;
      check($sformatf("urun dacdat k=%0d", k), 64'(dd0), 64'd0);
    end
    check("urun pulse count", 64'(und0_cnt - u_base), 64'd1);
    check("urun level", 64'(level0), 64'd0);
    brise();

    // Abort: second frame request while at k=10
    push_u(0, 64'h1234_0FFF);
    push_u(0, 64'h0000_8000);
    check("abort level", 64'(level0), 64'd2);
    a_base = abt0_cnt;
    exp1 = 32'h0FFF_1234;
    exp2 = 32'h8000_0000;
    kick();
    for (int k = 0; k <= 10; k++) begin
      brise();
      if (k == 0) audio_sample_clk = 1'b0;
      check($sformatf("abort f1 dacdat k=%0d", k), 64'(dd0), 64'(exp1[31-k]));
      check($sformatf("abort f1 daclrc k=%0d", k), 64'(lrc0), 64'(k == 0));
    end
    audio_sample_clk = 1'b1;
    brise();
    audio_sample_clk = 1'b0;
    check("abort pulse count", 64'(abt0_cnt - a_base), 64'd1);
    check("abort new daclrc", 64'(lrc0), 64'd1);
    check("abort new dacdat", 64'(dd0), 64'd1);
    check("abort level", 64'(level0), 64'd0);
    for (int k = 1; k < 32; k++) begin
      brise();
      check($sformatf("abort f2 dacdat k=%0d", k), 64'(dd0), 64'(exp2[31-k]));
    end
    brise();
    check("abort f2 idle dacdat", 64'(dd0), 64'd0);

    // I2S, 24-bit slots, ch0 all ones
    mode = 2'd1;
    push_u(1, 64'h0000_FFFF);
    kick();
    for (int k = 0; k <= 48; k++) begin
      brise();
      if (k == 0) audio_sample_clk = 1'b0;
      check($sformatf("i2s dacdat k=%0d", k), 64'(dd1), 64'(k >= 1 && k <= 16));
      check($sformatf("i2s daclrc k=%0d", k), 64'(lrc1), 64'(k >= 24));
    end
    brise();
    check("i2s idle dacdat", 64'(dd1), 64'd0);
    check("i2s idle daclrc", 64'(lrc1), 64'd1);

    // Left-justified, 4 channels, FIFO full boundary
    mode = 2'd2;
    push_u(2, 64'h0000_0000_0000_C000);
    push_u(2, 64'h1111_2222_3333_4444);
    push_u(2, 64'h5555_6666_7777_8888);
    push_u(2, 64'h9999_AAAA_BBBB_CCCC);
    check("lj level full", 64'(level2), 64'd4);
    check("lj s_ready full", 64'(s_ready2), 64'd0);
    push_u(2, 64'hDEAD_BEEF_DEAD_BEEF);
    check("lj level no overflow", 64'(level2), 64'd4);
    kick();
    brise();
    audio_sample_clk = 1'b0;
    check("lj level after start", 64'(level2), 64'd3);
    check("lj s_ready after start", 64'(s_ready2), 64'd1);
    check("lj daclrc k=0", 64'(lrc2), 64'd1);
    check("lj dacdat k=0", 64'(dd2), 64'd1);
    brise();
    check("lj dacdat k=1", 64'(dd2), 64'd1);
    for (int k = 2; k < 64; k++) begin
      brise();
      if (k == 2 || k == 15 || k == 16 || k == 40) begin
        check($sformatf("lj dacdat k=%0d", k), 64'(dd2), 64'd0);
        check($sformatf("lj daclrc k=%0d", k), 64'(lrc2), 64'(k < 16));
      end
    end
    brise();
    check("lj idle daclrc", 64'(lrc2), 64'd0);

    // Reset mid-frame at k=5
    mode = 2'd2;
    push_u(0, 64'hFFFF_FFFF);
    push_u(0, 64'hFFFF_FFFF);
    kick();
    for (int k = 0; k <= 5; k++) begin
      brise();
      if (k == 0) audio_sample_clk = 1'b0;
    end
    check("rst5 pre dacdat", 64'(dd0), 64'd1);
    check("rst5 pre daclrc", 64'(lrc0), 64'd1);
    @(negedge clk25);
    reset25 = 1'b1;
    @(posedge clk25);
    #1;
    check("rst5 dacdat", 64'(dd0), 64'd0);
    check("rst5 daclrc", 64'(lrc0), 64'd0);
    check("rst5 level", 64'(level0), 64'd0);
    check("rst5 s_ready", 64'(s_ready0), 64'd0);
    repeat (3) @(negedge clk25);
    reset25 = 1'b0;
    u_base = und0_cnt;
    for (int k = 0; k < 34; k++) begin
      brise();
      check($sformatf("post rst dacdat e=%0d", k), 64'(dd0), 64'd0);
      check($sformatf("post rst daclrc e=%0d", k), 64'(lrc0), 64'd0);
    end
    check("post rst no frame", 64'(und0_cnt - u_base), 64'd0);
    check("post rst level", 64'(level0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
